digit_entry_buffer: RTL

Operand entry stage directly upstream of the calculator state controller. Collects decoded keypad strobes into a signed BCD operand, debounces the raw enter pushbutton into a single-cycle enter pulse, and presents operand, sign and enter to the controller. The operand clears automatically after each accepted enter, ready for the next operand.

---
 rtl/digit_entry_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/digit_entry_buffer.sv
// Operand entry stage: collects keypad strobes into a signed BCD operand and turns the
// bouncy enter pushbutton into a single-cycle enter pulse for the calculator controller.
module digit_entry_buffer #(
  parameter int unsigned NUM_DIGITS      = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_key_valid,
  input  logic [3:0]                         i_key_code,
  input  logic                               i_enter_raw,
  input  logic                               i_enable,
  output logic [4*NUM_DIGITS-1:0]            o_val,
  output logic                               o_sign,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    o_digit_count,
  output logic                               o_full,
  output logic                               o_enter
);

  localparam int unsigned VW  = 4 * NUM_DIGITS;
  localparam int unsigned CW  = $clog2(NUM_DIGITS + 1);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0]  MaxCount = CW'(NUM_DIGITS);
  localparam logic [DBW-1:0] DbTarget = DBW'(DEBOUNCE_CYCLES);

  localparam logic [3:0] KeySign  = 4'hA;
  localparam logic [3:0] KeyBack  = 4'hB;
  localparam logic [3:0] KeyClear = 4'hC;

  logic           sync1_q, sync2_q;
  logic           db_level_q, db_level_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           enter_q, enter_d;

  logic [VW-1:0]  val_q, val_d;
  logic           sign_q, sign_d;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q, full_d;

  logic           key_accept;
  logic           is_digit;

  // Debounce: level flips only after the synchronized input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive samples; the enter pulse is registered alongside the flip.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    enter_d    = 1'b0;
    if (sync2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbTarget) begin
      db_level_d = sync2_q;
      db_cnt_d   = '0;
      enter_d    = sync2_q & i_enable;
    end else begin
      db_cnt_d = db_cnt_q + DBW'(1);
    end
  end

  assign key_accept = i_key_valid & i_enable & ~enter_q;
  assign is_digit   = (i_key_code <= 4'h9);

  always_comb begin
    val_d   = val_q;
    sign_d  = sign_q;
    count_d = count_q;
    if (enter_q) begin
      // Operand was held stable for the controller during the pulse; start fresh now.
      val_d   = '0;
      sign_d  = 1'b0;
      count_d = '0;
    end else if (key_accept) begin
      if (is_digit) begin
        if (!((count_q == '0) && (i_key_code == 4'h0)) && (count_q != MaxCount)) begin
          val_d   = {val_q[VW-5:0], i_key_code};
          count_d = count_q + CW'(1);
        end
      end else if (i_key_code == KeySign) begin
        if (count_q != '0) begin
          sign_d = ~sign_q;
        end
      end else if (i_key_code == KeyBack) begin
        if (count_q != '0) begin
          val_d   = {4'h0, val_q[VW-1:4]};
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            sign_d = 1'b0;
          end
        end
      end else if (i_key_code == KeyClear) begin
        val_d   = '0;
        sign_d  = 1'b0;
        count_d = '0;
      end
    end
  end

  assign full_d = (count_d == MaxCount);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      enter_q    <= 1'b0;
      val_q      <= '0;
      sign_q     <= 1'b0;
      count_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      sync1_q    <= i_enter_raw;
      sync2_q    <= sync1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      enter_q    <= enter_d;
      val_q      <= val_d;
      sign_q     <= sign_d;
      count_q    <= count_d;
      full_q     <= full_d;
    end
  end

  assign o_val         = val_q;
  assign o_sign        = sign_q;
  assign o_digit_count = count_q;
  assign o_full        = full_q;
  assign o_enter       = enter_q;

endmodule
